fpu_sched: RTL and testbench
============================

# fpu_sched

Two-requester scheduler that time-shares the single `FPU` instance between two clients. It arbitrates round-robin, latches the winner's operands, and issues a one-cycle `start` to the FPU. It then waits a fixed, parameterised latency, captures `Y`/`Overflow`/`Error`, and returns them with the requester ID over a valid/ready response channel. It sits between the client logic and `FPU`, and is the only driver of the FPU's operand and `start` inputs.

## Interface
- `LATENCY`, default 8: cycles from the edge that samples `fpu_start`=1 to the edge at which `fpu_Y`/`fpu_Overflow`/`fpu_Error` are valid. Legal range 1..255.
- `Clock` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` input 1: request present.
- `req0_ready`, `req1_ready` output 1: request accepted this cycle (transfer on valid&ready).
- `req0_A`, `req0_B`, `req1_A`, `req1_B` input 32: IEEE-754 single operands.
- `req0_Sel`, `req1_Sel` input 2: operation; 00 add, 01 sub, 10 mul, 11 div.
- `req0_round`, `req1_round` input 1: rounding-mode bit, passed through to the FPU.
- `fpu_A`, `fpu_B` output 32: operands to the FPU.
- `fpu_Sel` output 2: operation select to the FPU.
- `fpu_round` output 1: rounding bit to the FPU.
- `fpu_start` output 1: one-cycle start pulse.
- `fpu_Y` input 32: FPU result.
- `fpu_Overflow`, `fpu_Error` input 1: FPU status flags.
- `rsp_valid` output 1: response held until accepted.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output 1: requester that issued the operation.
- `rsp_Y` output 32: captured result.
- `rsp_Overflow`, `rsp_Error` output 1: captured status flags.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset value is IDLE.
- **IDLE, grant selection**
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester not granted last is chosen. The priority pointer `last` resets to 1, so req0 wins the first tie.
  - `reqN_ready` is combinational: it is high only for the granted requester, and only in IDLE. It is never high for both in the same cycle.
- **IDLE, on transfer**
  - Latch A, B, Sel and round into the operand registers.
  - Set `rsp_id` to the granted N and set `last` to N.
  - Go to ISSUE.
- **ISSUE**
  - `fpu_start`=1 for exactly this cycle.
  - The operand registers drive `fpu_*`.
  - Load `cnt`=LATENCY-1 and go to WAIT.
- **WAIT**
  - `fpu_*` operands are held stable.
  - If `cnt`≠0, decrement. If `cnt`=0, capture `fpu_Y`, `fpu_Overflow` and `fpu_Error` into the `rsp_*` registers and go to RESP.
- **RESP**
  - `rsp_valid`=1, with `rsp_*` stable.
  - On `rsp_ready`=1, go to IDLE. No new request is accepted in this cycle.
- **Requests while not in IDLE:** requests are held off with `ready`=0. Requesters must keep `valid` and operands stable until they receive `ready`.
- **Output values:** `fpu_A`, `fpu_B`, `fpu_Sel` and `fpu_round` keep their last values outside ISSUE/WAIT. They are not zeroed.
- **No interpretation of results:** the block never inspects operands or results. Inf, NaN, zero-divide and overflow results pass through unchanged via `rsp_Error`/`rsp_Overflow`.
- **Reset mid-operation:** reset at any point returns the FSM to IDLE and drops any in-flight operation (no response is produced). `last` returns to 1.
- **Reset values of outputs:**
  - `req0_ready`, `req1_ready` = 0.
  - `fpu_start` = 0.
  - `fpu_A`, `fpu_B` = 0; `fpu_Sel` = 00; `fpu_round` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0.
  - `rsp_Y` = 0, `rsp_Overflow` = 0, `rsp_Error` = 0.
  - `busy` = 0.

## Timing
- Cycle numbering: accept edge E0 (valid&ready sampled); ISSUE is the cycle after E0; E1 is the first edge sampling `fpu_start`=1.
- Capture happens at edge E1+LATENCY, so `rsp_valid` rises after E1+LATENCY (E0+1+LATENCY).
- With `rsp_ready` held high, the next accept is possible at E0+LATENCY+3, giving minimum issue spacing of LATENCY+3 cycles.
- `fpu_start` is never high on two consecutive cycles.
- `fpu_*` operands are stable from the ISSUE cycle through the capture edge.

## Structure
- Shared package `fpu_pkg` holds:
  - the Sel encodings `FPU_ADD`/`FPU_SUB`/`FPU_MUL`/`FPU_DIV`;
  - the FSM state encoding (2 bits);
  - the default `LATENCY`.
- One sub-module, `fpu_rr_arb2`: a combinational 2-way round-robin grant taking (`valid[1:0]`, `last`) and producing a one-hot grant.
- FSM, counter and registers live in `fpu_sched`.

## Test plan
Every scenario uses LATENCY=8.
- **Single request, add.** req0 sends A=0x3F800000, B=0x40000000, Sel=00. Expect:
  - one `fpu_start` pulse;
  - `rsp_valid` 9 cycles after accept;
  - `rsp_id`=0, `rsp_Y`=0x40400000 (3.0), `rsp_Overflow`=0, `rsp_Error`=0.
- **Simultaneous requests after reset.** req0 and req1 both valid. Expect:
  - req0 is granted first and req1 second;
  - responses arrive in order, with `rsp_id` 0 then 1;
  - `req1_ready` stays 0 until the FSM is back in IDLE.
- **Fairness.** Both requesters held valid for 4 operations. Expect grants to alternate 0, 1, 0, 1, with accept edges spaced exactly 11 cycles apart when `rsp_ready`=1.
- **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles while a request is pending. Expect:
  - `rsp_Y` and `rsp_id` stay stable while `rsp_valid`=1;
  - the pending request is not accepted until the cycle after `rsp_ready` goes high.
- **Error passthrough.** Sel=11, A=0x7F800000 (+inf), B=0. Expect `rsp_Error` to equal the FPU's `Error` output, with no change to FSM timing.
- **Reset mid-operation.** Assert `Reset` low during WAIT. Expect:
  - all outputs take their reset values immediately (asynchronously);
  - no `rsp_valid` for the dropped operation;
  - the next request after release behaves exactly like the single-request add case.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU scheduler: operation encodings, FSM states
// and the default FPU latency.
package fpu_pkg;

  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_SUB = 2'b01;
  localparam logic [1:0] FPU_MUL = 2'b10;
  localparam logic [1:0] FPU_DIV = 2'b11;

  localparam int unsigned FPU_DEFAULT_LATENCY = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Combinational two-way round-robin arbiter; on a tie the requester that was
// not granted last wins.
module fpu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_sched.sv
// Time-shares one FPU between two requesters: round-robin accept, one-cycle
// start, fixed-latency wait, then a held valid/ready response.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = FPU_DEFAULT_LATENCY
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [1:0]  req0_Sel,
  input  logic        req0_round,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [1:0]  req1_Sel,
  input  logic        req1_round,
  output logic [31:0] fpu_A,
  output logic [31:0] fpu_B,
  output logic [1:0]  fpu_Sel,
  output logic        fpu_round,
  output logic        fpu_start,
  input  logic [31:0] fpu_Y,
  input  logic        fpu_Overflow,
  input  logic        fpu_Error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_Y,
  output logic        rsp_Overflow,
  output logic        rsp_Error,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on an edge where reqN_valid & reqN_ready;
  // the response transfers on an edge where rsp_valid & rsp_ready, and rsp_*
  // stay stable from rsp_valid rising until that edge.

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  sched_state_t state_q, state_d;
  logic         last_q, last_d;
  logic [31:0]  a_q, a_d;
  logic [31:0]  b_q, b_d;
  logic [1:0]   sel_q, sel_d;
  logic         round_q, round_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         rsp_id_q, rsp_id_d;
  logic [31:0]  rsp_y_q, rsp_y_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         rsp_err_q, rsp_err_d;

  logic [1:0]   grant;
  logic         in_idle;

  fpu_rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (grant)
  );

  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = in_idle & grant[0];
  assign req1_ready = in_idle & grant[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    rsp_id_d  = rsp_id_q;
    rsp_y_d   = rsp_y_q;
    rsp_ovf_d = rsp_ovf_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        // The grant is already qualified by valid, so any grant is a transfer.
        if (grant[1]) begin
          a_d      = req1_A;
          b_d      = req1_B;
          sel_d    = req1_Sel;
          round_d  = req1_round;
          rsp_id_d = 1'b1;
          last_d   = 1'b1;
          state_d  = ST_ISSUE;
        end else if (grant[0]) begin
          a_d      = req0_A;
          b_d      = req0_B;
          sel_d    = req0_Sel;
          round_d  = req0_round;
          rsp_id_d = 1'b0;
          last_d   = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rsp_y_d   = fpu_Y;
          rsp_ovf_d = fpu_Overflow;
          rsp_err_d = fpu_Error;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 2'b00;
      round_q   <= 1'b0;
      cnt_q     <= '0;
      rsp_id_q  <= 1'b0;
      rsp_y_q   <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      round_q   <= round_d;
      cnt_q     <= cnt_d;
      rsp_id_q  <= rsp_id_d;
      rsp_y_q   <= rsp_y_d;
      rsp_ovf_q <= rsp_ovf_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Operand registers drive the FPU directly, so they hold their last values
  // outside an operation rather than returning to zero.
  assign fpu_A        = a_q;
  assign fpu_B        = b_q;
  assign fpu_Sel      = sel_q;
  assign fpu_round    = round_q;
  assign fpu_start    = (state_q == ST_ISSUE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_Y        = rsp_y_q;
  assign rsp_Overflow = rsp_ovf_q;
  assign rsp_Error    = rsp_err_q;
  assign busy         = !in_idle;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched with a fixed-latency FPU stand-in and an
// expected-response queue filled at accept time.
module tb_fpu_sched;
  import fpu_pkg::*;

  localparam int LAT = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic        rnd;
  } op_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0]  req0_Sel, req1_Sel;
  logic        req0_round, req1_round;
  logic [31:0] fpu_A, fpu_B, fpu_Y;
  logic [1:0]  fpu_Sel;
  logic        fpu_round, fpu_start, fpu_Overflow, fpu_Error;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_Overflow, rsp_Error, busy;
  logic [31:0] rsp_Y;
  logic [1:0]  dbg_state;

  fpu_sched #(.LATENCY(LAT)) dut (
    .Clock(Clock), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A),
    .req0_B(req0_B), .req0_Sel(req0_Sel), .req0_round(req0_round),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A),
    .req1_B(req1_B), .req1_Sel(req1_Sel), .req1_round(req1_round),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_Sel(fpu_Sel), .fpu_round(fpu_round),
    .fpu_start(fpu_start), .fpu_Y(fpu_Y), .fpu_Overflow(fpu_Overflow),
    .fpu_Error(fpu_Error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_Y(rsp_Y), .rsp_Overflow(rsp_Overflow),
    .rsp_Error(rsp_Error), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  // ---------------- FPU stand-in ----------------
  // Returns {Y, Overflow, Error}; the 1.0+2.0 and x/0 cases are exact.
  function automatic logic [33:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sel, input logic rnd);
    logic [31:0] y;
    if (sel == FPU_ADD && a == 32'h3F800000 && b == 32'h40000000)
      return {32'h40400000, 2'b00};
    if (sel == FPU_DIV && b[30:0] == 31'd0)
      return {((a[31] ^ b[31]) ? 32'hFF800000 : 32'h7F800000), 2'b01};
    y = (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {29'd0, rnd, sel};
    return {y, y[31] ^ y[0], 1'b0};
  endfunction

  // Result is only meaningful during the single cycle before the capture edge.
  logic [LAT:1] pipe;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) pipe <= '0;
    else        pipe <= {pipe[LAT-1:1], fpu_start};
  end

  always_comb begin
    {fpu_Y, fpu_Overflow, fpu_Error} = {32'hDEADBEEF, 2'b11};
    if (pipe[LAT]) {fpu_Y, fpu_Overflow, fpu_Error} = fpu_model(fpu_A, fpu_B, fpu_Sel, fpu_round);
  end

  // ---------------- scoreboard state ----------------
  op_t         q0[$], q1[$];
  logic [34:0] exp_q[$];
  int          acc_ids[$], acc_edges[$], rsp_ids[$];
  int          checks = 0, errors = 0;
  int          rsp_cnt = 0, start_cnt = 0, rsp_hs_edge = 0, last_acc = 0;
  logic [34:0] last_rsp, prev_rsp;
  logic        acc_pend0 = 1'b0, acc_pend1 = 1'b0;
  logic        prev_rsp_valid = 1'b0, prev_rsp_ready = 1'b0, prev_start = 1'b0;
  op_t         drv_op;

  // ---------------- request driver ----------------
  always @(posedge Clock) begin
    #1;
    if (!Reset) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      acc_pend0 = 1'b0;  acc_pend1 = 1'b0;
    end else begin
      if (acc_pend0) begin req0_valid = 1'b0; acc_pend0 = 1'b0; end
      if (acc_pend1) begin req1_valid = 1'b0; acc_pend1 = 1'b0; end
      if (!req0_valid && q0.size() > 0) begin
        drv_op = q0.pop_front();
        {req0_A, req0_B, req0_Sel, req0_round} = drv_op;
        req0_valid = 1'b1;
      end
      if (!req1_valid && q1.size() > 0) begin
        drv_op = q1.pop_front();
        {req1_A, req1_B, req1_Sel, req1_round} = drv_op;
        req1_valid = 1'b1;
      end
    end
  end

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] sel, input logic rnd);
    op_t op;
    op = '{a: a, b: b, sel: sel, rnd: rnd};
    if (id == 0) q0.push_back(op);
    else         q1.push_back(op);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clock) begin
    if (!Reset) begin
      prev_rsp_valid = 1'b0; prev_rsp_ready = 1'b0; prev_start = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        acc_pend0 = 1'b1; acc_ids.push_back(0); acc_edges.push_back(cyc + 1); last_acc = cyc + 1;
        exp_q.push_back({1'b0, fpu_model(req0_A, req0_B, req0_Sel, req0_round)});
      end
      if (req1_valid && req1_ready) begin
        acc_pend1 = 1'b1; acc_ids.push_back(1); acc_edges.push_back(cyc + 1); last_acc = cyc + 1;
        exp_q.push_back({1'b1, fpu_model(req1_A, req1_B, req1_Sel, req1_round)});
      end
      checks++;
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL both_ready: got req0_ready=1 req1_ready=1 expected at most one");
      end
      checks++;
      if ((req0_ready || req1_ready) && busy) begin
        errors++; $display("FAIL ready_outside_idle: got ready=1 with state %0d expected ready=0", dbg_state);
      end
      if (fpu_start) begin
        start_cnt++;
        checks++;
        if (prev_start) begin errors++; $display("FAIL start_twice: got fpu_start on two consecutive cycles"); end
        checks++;
        if (cyc != last_acc) begin
          errors++; $display("FAIL start_timing: got start after edge %0d expected after edge %0d", cyc, last_acc);
        end
      end
      if (rsp_valid && !prev_rsp_valid) begin
        checks++;
        if (cyc != last_acc + LAT + 1) begin
          errors++; $display("FAIL rsp_latency: got rsp_valid after edge %0d expected after edge %0d", cyc, last_acc + LAT + 1);
        end
      end
      if (rsp_valid && prev_rsp_valid && !prev_rsp_ready) begin
        checks++;
        if ({rsp_id, rsp_Y, rsp_Overflow, rsp_Error} !== prev_rsp) begin
          errors++; $display("FAIL rsp_stable: got %h expected %h", {rsp_id, rsp_Y, rsp_Overflow, rsp_Error}, prev_rsp);
        end
      end
      if (rsp_valid && rsp_ready) begin
        last_rsp = {rsp_id, rsp_Y, rsp_Overflow, rsp_Error};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rsp_unexpected: got %h expected no response", last_rsp);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          if (last_rsp !== e) begin
            errors++; $display("FAIL rsp_data: got %h expected %h", last_rsp, e);
          end
        end
        rsp_cnt++; rsp_ids.push_back(int'(rsp_id)); rsp_hs_edge = cyc + 1;
      end
      prev_rsp_valid = rsp_valid;
      prev_rsp_ready = rsp_ready;
      prev_start     = fpu_start;
      prev_rsp       = {rsp_id, rsp_Y, rsp_Overflow, rsp_Error};
    end
  end

  task automatic wait_rsp(input int n, input int budget, input string name);
    int i = 0;
    while (rsp_cnt < n && i < budget) begin @(negedge Clock); i++; end
    checks++;
    if (rsp_cnt < n) begin
      errors++; $display("FAIL %s_timeout: got %0d responses expected %0d", name, rsp_cnt, n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clock); Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if ({req0_ready, req1_ready, fpu_start} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_start: got %b expected 000", {req0_ready, req1_ready, fpu_start}); end
    checks++; if ({fpu_A, fpu_B, fpu_Sel, fpu_round} !== 67'd0) begin
      errors++; $display("FAIL reset_fpu_ops: got %h expected 0", {fpu_A, fpu_B, fpu_Sel, fpu_round}); end
    checks++; if ({rsp_valid, rsp_id} !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid_id: got %b expected 00", {rsp_valid, rsp_id}); end
    checks++; if ({rsp_Y, rsp_Overflow, rsp_Error} !== 34'd0) begin
      errors++; $display("FAIL reset_rsp_data: got %h expected 0", {rsp_Y, rsp_Overflow, rsp_Error}); end
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_busy_state: got busy=%b state=%0d expected 0/0", busy, dbg_state); end
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got busy=%b ready=%b expected 0/0", busy, req0_ready); end
  endtask

  task automatic test_single_add(input string name);
    int n, s, r;
    n = acc_ids.size(); s = start_cnt; r = rsp_cnt;
    rsp_ready = 1'b1;
    drive_req(0, 32'h3F800000, 32'h40000000, FPU_ADD, 1'b0);
    wait_rsp(r + 1, 40, name);
    checks++; if (start_cnt - s != 1) begin
      errors++; $display("FAIL %s_start_count: got %0d expected 1", name, start_cnt - s); end
    checks++; if (acc_ids.size() != n + 1 || acc_ids[n] != 0) begin
      errors++; $display("FAIL %s_grant: got %0d accepts expected 1 from req0", name, acc_ids.size() - n); end
    checks++; if (last_rsp !== {1'b0, 32'h40400000, 2'b00}) begin
      errors++; $display("FAIL %s_result: got %h expected %h", name, last_rsp, {1'b0, 32'h40400000, 2'b00}); end
  endtask

  task automatic test_simultaneous(input string name);
    int n, r, i;
    n = acc_ids.size(); r = rsp_cnt; i = 0;
    rsp_ready = 1'b1;
    drive_req(0, $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    drive_req(1, $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    while (acc_ids.size() < n + 1 && i < 20) begin @(negedge Clock); i++; end
    while (rsp_cnt < r + 1 && i < 40) begin
      @(negedge Clock); i++;
      checks++;
      if (busy && req1_ready) begin errors++; $display("FAIL %s_req1_held: got req1_ready=1 expected 0 while busy", name); end
    end
    wait_rsp(r + 2, 40, name);
    checks++; if (acc_ids.size() < n + 2 || acc_ids[n] != 0 || acc_ids[n+1] != 1) begin
      errors++; $display("FAIL %s_grant_order: got %0d accepts expected req0 then req1", name, acc_ids.size() - n); end
    checks++; if (rsp_ids.size() < r + 2 || rsp_ids[r] != 0 || rsp_ids[r+1] != 1) begin
      errors++; $display("FAIL %s_rsp_order: got %0d responses expected id 0 then 1", name, rsp_ids.size() - r); end
  endtask

  task automatic test_fairness();
    int n, r;
    n = acc_ids.size(); r = rsp_cnt;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_req(0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drive_req(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    wait_rsp(r + 4, 80, "fairness");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (acc_ids.size() < n + 4 || acc_ids[n+k] != (k % 2)) begin
        errors++; $display("FAIL fairness_grant%0d: got %0d expected %0d", k,
                           (acc_ids.size() > n + k) ? acc_ids[n+k] : -1, k % 2);
      end else if (k > 0) begin
        checks++;
        if (acc_edges[n+k] - acc_edges[n+k-1] != LAT + 3) begin
          errors++; $display("FAIL fairness_spacing%0d: got %0d expected %0d", k,
                             acc_edges[n+k] - acc_edges[n+k-1], LAT + 3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n, r, i;
    n = acc_ids.size(); r = rsp_cnt; i = 0;
    rsp_ready = 1'b0;
    drive_req(0, $urandom, $urandom, FPU_MUL, 1'b1);
    while (!rsp_valid && i < 30) begin @(negedge Clock); i++; end
    checks++; if (!rsp_valid) begin errors++; $display("FAIL bp_rsp_valid: got 0 expected 1"); end
    drive_req(1, $urandom, $urandom, FPU_SUB, 1'b0);
    repeat (5) @(negedge Clock);
    checks++; if (acc_ids.size() != n + 1 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_held_off: got %0d accepts rsp_valid=%b expected 1 accept rsp_valid=1",
                         acc_ids.size() - n, rsp_valid); end
    @(posedge Clock); #1 rsp_ready = 1'b1;
    i = 0;
    while (acc_ids.size() < n + 2 && i < 10) begin @(negedge Clock); i++; end
    checks++; if (acc_ids.size() < n + 2 || acc_ids[n+1] != 1 || acc_edges[n+1] != rsp_hs_edge + 1) begin
      errors++; $display("FAIL bp_accept_edge: got edge %0d expected %0d",
                         (acc_edges.size() > n + 1) ? acc_edges[n+1] : -1, rsp_hs_edge + 1); end
    wait_rsp(r + 2, 40, "bp");
  endtask

  task automatic test_error();
    int r;
    r = rsp_cnt;
    rsp_ready = 1'b1;
    drive_req(1, 32'h7F800000, 32'h00000000, FPU_DIV, 1'b0);
    wait_rsp(r + 1, 40, "error");
    checks++; if (last_rsp !== {1'b1, 32'h7F800000, 2'b01}) begin
      errors++; $display("FAIL error_passthrough: got %h expected %h", last_rsp, {1'b1, 32'h7F800000, 2'b01}); end
  endtask

  task automatic test_reset_mid();
    int r, i, n;
    r = rsp_cnt; i = 0;
    rsp_ready = 1'b1;
    drive_req(0, $urandom, $urandom, FPU_MUL, 1'b1);
    while (dbg_state !== ST_WAIT && i < 20) begin @(negedge Clock); i++; end
    repeat (3) @(negedge Clock);
    checks++; if (dbg_state !== ST_WAIT) begin
      errors++; $display("FAIL mid_reach_wait: got state %0d expected %0d", dbg_state, ST_WAIT); end
    #2 Reset = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready, fpu_start, fpu_A, fpu_B, fpu_Sel, fpu_round, rsp_valid,
                   rsp_id, rsp_Y, rsp_Overflow, rsp_Error, busy} !== '0) begin
      errors++; $display("FAIL mid_async_reset: got busy=%b fpu_A=%h rsp_Y=%h expected all zero", busy, fpu_A, rsp_Y); end
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge Clock);
      checks++;
      if (rsp_valid) begin errors++; $display("FAIL mid_dropped_rsp: got rsp_valid=1 expected 0"); end
    end
    checks++; if (rsp_cnt != r) begin errors++; $display("FAIL mid_rsp_count: got %0d expected %0d", rsp_cnt, r); end
    test_single_add("after_reset");
    // A tie right after reset must go to req0 because the pointer was reset.
    n = acc_ids.size();
    pulse_reset();
    test_simultaneous("tie_after_reset");
    checks++; if (acc_ids.size() < n + 1 || acc_ids[n] != 0) begin
      errors++; $display("FAIL mid_last_reset: expected req0 to win first tie"); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_A = '0; req0_B = '0; req0_Sel = '0; req0_round = 1'b0;
    req1_A = '0; req1_B = '0; req1_Sel = '0; req1_round = 1'b0;
    test_reset();
    test_single_add("single_add");
    pulse_reset();
    test_simultaneous("simultaneous");
    test_fairness();
    test_backpressure();
    test_error();
    test_reset_mid();
    repeat (3) @(negedge Clock);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
